// File: rtl/jogo_pkg.sv
// jogo_pkg: state codes and widths shared by the memory-game control unit
package jogo_pkg;
  localparam int ESTADO_W = 4;
  localparam logic [ESTADO_W-1:0] ST_INICIAL           = 4'h0;
  localparam logic [ESTADO_W-1:0] ST_PREPARACAO        = 4'h1;
  localparam logic [ESTADO_W-1:0] ST_LE_MEMORIA        = 4'h2;
  localparam logic [ESTADO_W-1:0] ST_MOSTRA_LED        = 4'h3;
  localparam logic [ESTADO_W-1:0] ST_ESPERA_LED        = 4'h4;
  localparam logic [ESTADO_W-1:0] ST_APAGA_LED         = 4'h5;
  localparam logic [ESTADO_W-1:0] ST_PROXIMO_LED       = 4'h6;
  localparam logic [ESTADO_W-1:0] ST_INICIA_RODADA     = 4'h7;
  localparam logic [ESTADO_W-1:0] ST_ESPERA_JOGADA     = 4'h8;
  localparam logic [ESTADO_W-1:0] ST_REGISTRA          = 4'h9;
  localparam logic [ESTADO_W-1:0] ST_COMPARACAO        = 4'hA;
  localparam logic [ESTADO_W-1:0] ST_PROXIMA_JOGADA    = 4'hB;
  localparam logic [ESTADO_W-1:0] ST_PROXIMA_SEQUENCIA = 4'hC;
  localparam logic [ESTADO_W-1:0] ST_FIM_ACERTOU       = 4'hD;
  localparam logic [ESTADO_W-1:0] ST_FIM_ERROU         = 4'hE;
  localparam logic [ESTADO_W-1:0] ST_FIM_TIMEOUT       = 4'hF;
endpackage

// File: rtl/unidade_controle.sv
// unidade_controle: Moore FSM sequencing the memory-game datapath
module unidade_controle
  import jogo_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic                iniciar,
  input  logic                nivel,
  input  logic                igual,
  input  logic                fim_sequencia,
  input  logic                ultima_sequencia,
  input  logic                jogada_feita,
  input  logic                fim_timer,
  input  logic                fim_timer_leds,
  input  logic                fimE,
  output logic                zeraR,
  output logic                registraR,
  output logic                limpaM,
  output logic                registraM,
  output logic                contaE,
  output logic                zeraE,
  output logic                contaL,
  output logic                zeraL,
  output logic                zera_timer,
  output logic                conta_timer,
  output logic                zera_timer_leds,
  output logic                conta_timer_leds,
  output logic                sel_nivel,
  output logic                pronto,
  output logic                acertou,
  output logic                errou,
  output logic                timeout,
  output logic [ESTADO_W-1:0] db_estado
);
  logic [ESTADO_W-1:0] estado, proximo;
  logic                fim_e_unused;
  assign fim_e_unused = fimE;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado    <= ST_INICIAL;
      sel_nivel <= 1'b0;
    end else begin
      estado <= proximo;
      if (estado == ST_PREPARACAO) sel_nivel <= nivel;
    end
  end
  always_comb begin
    proximo = ST_INICIAL;
    case (estado)
      ST_INICIAL:           proximo = iniciar ? ST_PREPARACAO : ST_INICIAL;
      ST_PREPARACAO:        proximo = ST_LE_MEMORIA;
      ST_LE_MEMORIA:        proximo = ST_MOSTRA_LED;
      ST_MOSTRA_LED:        proximo = ST_ESPERA_LED;
      ST_ESPERA_LED:        proximo = fim_timer_leds ? ST_APAGA_LED : ST_ESPERA_LED;
      ST_APAGA_LED:         proximo = fim_sequencia ? ST_INICIA_RODADA : ST_PROXIMO_LED;
      ST_PROXIMO_LED:       proximo = ST_LE_MEMORIA;
      ST_INICIA_RODADA:     proximo = ST_ESPERA_JOGADA;
      // a move arriving together with the timeout still counts as a move
      ST_ESPERA_JOGADA:     proximo = jogada_feita ? ST_REGISTRA :
                                      fim_timer    ? ST_FIM_TIMEOUT : ST_ESPERA_JOGADA;
      ST_REGISTRA:          proximo = ST_COMPARACAO;
      ST_COMPARACAO:        proximo = !igual                            ? ST_FIM_ERROU :
                                      fim_sequencia && ultima_sequencia ? ST_FIM_ACERTOU :
                                      fim_sequencia                     ? ST_PROXIMA_SEQUENCIA :
                                                                          ST_PROXIMA_JOGADA;
      ST_PROXIMA_JOGADA:    proximo = ST_ESPERA_JOGADA;
      ST_PROXIMA_SEQUENCIA: proximo = ST_LE_MEMORIA;
      ST_FIM_ACERTOU:       proximo = iniciar ? ST_PREPARACAO : ST_FIM_ACERTOU;
      ST_FIM_ERROU:         proximo = iniciar ? ST_PREPARACAO : ST_FIM_ERROU;
      ST_FIM_TIMEOUT:       proximo = iniciar ? ST_PREPARACAO : ST_FIM_TIMEOUT;
      default:              proximo = ST_INICIAL;
    endcase
  end
  assign zeraR            = estado == ST_PREPARACAO;
  assign zeraL            = estado == ST_PREPARACAO;
  assign registraR        = estado == ST_REGISTRA;
  assign registraM        = estado == ST_MOSTRA_LED;
  assign limpaM           = estado == ST_PREPARACAO || estado == ST_APAGA_LED;
  assign contaE           = estado == ST_PROXIMO_LED || estado == ST_PROXIMA_JOGADA;
  assign zeraE            = estado == ST_PREPARACAO || estado == ST_INICIA_RODADA ||
                            estado == ST_PROXIMA_SEQUENCIA;
  assign contaL           = estado == ST_PROXIMA_SEQUENCIA;
  assign zera_timer       = estado == ST_PREPARACAO || estado == ST_INICIA_RODADA ||
                            estado == ST_REGISTRA;
  assign conta_timer      = estado == ST_ESPERA_JOGADA;
  assign zera_timer_leds  = estado == ST_PREPARACAO || estado == ST_MOSTRA_LED ||
                            estado == ST_APAGA_LED;
  assign conta_timer_leds = estado == ST_ESPERA_LED;
  assign acertou          = estado == ST_FIM_ACERTOU;
  assign errou            = estado == ST_FIM_ERROU;
  assign timeout          = estado == ST_FIM_TIMEOUT;
  assign pronto           = acertou || errou || timeout;
  assign db_estado        = estado;
endmodule

// File: tb/tb_unidade_controle.sv
// tb_unidade_controle: table-driven check of the memory-game control FSM
module tb_unidade_controle;
  logic clock = 1'b0, reset = 1'b1;
  logic iniciar = 1'b0, nivel = 1'b0, igual = 1'b0, fim_sequencia = 1'b0;
  logic ultima_sequencia = 1'b0, jogada_feita = 1'b0, fim_timer = 1'b0;
  logic fim_timer_leds = 1'b0, fimE = 1'b0;
  logic zeraR, registraR, limpaM, registraM, contaE, zeraE, contaL, zeraL;
  logic zera_timer, conta_timer, zera_timer_leds, conta_timer_leds;
  logic sel_nivel, pronto, acertou, errou, timeout;
  logic [3:0] db_estado;
  int passed = 0, total = 0;
  localparam logic [7:0] I = 8'h80, N = 8'h40, G = 8'h20, FS = 8'h10;
  localparam logic [7:0] U = 8'h08, J = 8'h04, FT = 8'h02, FL = 8'h01;
  typedef struct {
    logic [7:0] in;
    logic [3:0] est;
    logic       sel;
  } vec_t;
  vec_t tbl[$];
  always #5 clock = ~clock;
  unidade_controle dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .nivel(nivel), .igual(igual),
    .fim_sequencia(fim_sequencia), .ultima_sequencia(ultima_sequencia),
    .jogada_feita(jogada_feita), .fim_timer(fim_timer), .fim_timer_leds(fim_timer_leds),
    .fimE(fimE), .zeraR(zeraR), .registraR(registraR), .limpaM(limpaM),
    .registraM(registraM), .contaE(contaE), .zeraE(zeraE), .contaL(contaL), .zeraL(zeraL),
    .zera_timer(zera_timer), .conta_timer(conta_timer), .zera_timer_leds(zera_timer_leds),
    .conta_timer_leds(conta_timer_leds), .sel_nivel(sel_nivel), .pronto(pronto),
    .acertou(acertou), .errou(errou), .timeout(timeout), .db_estado(db_estado)
  );
  // strobe order: zeraR registraR limpaM registraM contaE zeraE contaL zeraL
  //               zera_timer conta_timer zera_timer_leds conta_timer_leds pronto acertou errou timeout
  function automatic logic [15:0] exp_out(input logic [3:0] s);
    case (s)
      4'h1:    return 16'b1010_0101_1010_0000;
      4'h3:    return 16'b0001_0000_0010_0000;
      4'h4:    return 16'b0000_0000_0001_0000;
      4'h5:    return 16'b0010_0000_0010_0000;
      4'h6:    return 16'b0000_1000_0000_0000;
      4'h7:    return 16'b0000_0100_1000_0000;
      4'h8:    return 16'b0000_0000_0100_0000;
      4'h9:    return 16'b0100_0000_1000_0000;
      4'hB:    return 16'b0000_1000_0000_0000;
      4'hC:    return 16'b0000_0110_0000_0000;
      4'hD:    return 16'b0000_0000_0000_1100;
      4'hE:    return 16'b0000_0000_0000_1010;
      4'hF:    return 16'b0000_0000_0000_1001;
      default: return 16'b0;
    endcase
  endfunction
  task automatic check(input string name, input logic [3:0] est, input logic sel);
    logic [20:0] act, req;
    act = {db_estado, zeraR, registraR, limpaM, registraM, contaE, zeraE, contaL, zeraL,
           zera_timer, conta_timer, zera_timer_leds, conta_timer_leds,
           pronto, acertou, errou, timeout, sel_nivel};
    req = {est, exp_out(est), sel};
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got estado=%h out=%b sel=%b, want estado=%h out=%b sel=%b",
                  name, act[20:17], act[16:1], act[0], req[20:17], req[16:1], req[0]);
  endtask
  task automatic drive(input logic [7:0] v);
    {iniciar, nivel, igual, fim_sequencia, ultima_sequencia, jogada_feita, fim_timer,
     fim_timer_leds} = v;
  endtask
  task automatic step(input logic [7:0] v);
    drive(v);
    @(posedge clock);
    #1;
  endtask
  initial begin
    repeat (2) @(posedge clock);
    #1;
    check("reset_hold", 4'h0, 1'b0);
    reset = 1'b0;
    step(I | N); check("seq_prep", 4'h1, 1'b0);
    step(N);     check("seq_le", 4'h2, 1'b1);
    step(N);     check("seq_mostra", 4'h3, 1'b1);
    step(N);     check("seq_espera", 4'h4, 1'b1);
    #2 reset = 1'b1;
    #1 check("reset_async", 4'h0, 1'b0);
    @(posedge clock);
    #1 reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step(N);
      check("idle_after_reset", 4'h0, 1'b0);
    end
    tbl.push_back('{I | N, 4'h1, 1'b0});
    tbl.push_back('{N, 4'h2, 1'b1});
    tbl.push_back('{N, 4'h3, 1'b1});
    tbl.push_back('{N, 4'h4, 1'b1});
    tbl.push_back('{N, 4'h4, 1'b1});
    tbl.push_back('{N, 4'h4, 1'b1});
    tbl.push_back('{N | FL, 4'h5, 1'b1});
    tbl.push_back('{N | FS, 4'h7, 1'b1});
    tbl.push_back('{N, 4'h8, 1'b1});
    tbl.push_back('{N | J, 4'h9, 1'b1});
    tbl.push_back('{N | G | FS, 4'hA, 1'b1});
    tbl.push_back('{N | G | FS, 4'hC, 1'b1});
    tbl.push_back('{N | I, 4'h2, 1'b1});
    tbl.push_back('{N, 4'h3, 1'b1});
    tbl.push_back('{N | FL, 4'h4, 1'b1});
    tbl.push_back('{N | FL, 4'h5, 1'b1});
    tbl.push_back('{N | FS, 4'h7, 1'b1});
    tbl.push_back('{N, 4'h8, 1'b1});
    tbl.push_back('{N | J | FT, 4'h9, 1'b1});
    tbl.push_back('{N, 4'hA, 1'b1});
    tbl.push_back('{N | FS | U, 4'hE, 1'b1});
    tbl.push_back('{N, 4'hE, 1'b1});
    tbl.push_back('{I | N, 4'h1, 1'b1});
    tbl.push_back('{N, 4'h2, 1'b1});
    tbl.push_back('{N, 4'h3, 1'b1});
    tbl.push_back('{N | FL, 4'h4, 1'b1});
    tbl.push_back('{N | FL, 4'h5, 1'b1});
    tbl.push_back('{N | FS, 4'h7, 1'b1});
    tbl.push_back('{N, 4'h8, 1'b1});
    tbl.push_back('{N | I, 4'h8, 1'b1});
    tbl.push_back('{N | FT, 4'hF, 1'b1});
    tbl.push_back('{N, 4'hF, 1'b1});
    tbl.push_back('{I, 4'h1, 1'b1});
    tbl.push_back('{8'h00, 4'h2, 1'b0});
    tbl.push_back('{8'h00, 4'h3, 1'b0});
    tbl.push_back('{FL, 4'h4, 1'b0});
    tbl.push_back('{FL, 4'h5, 1'b0});
    tbl.push_back('{FS, 4'h7, 1'b0});
    tbl.push_back('{N, 4'h8, 1'b0});
    tbl.push_back('{N | J, 4'h9, 1'b0});
    tbl.push_back('{N, 4'hA, 1'b0});
    tbl.push_back('{N | G, 4'hB, 1'b0});
    tbl.push_back('{N, 4'h8, 1'b0});
    tbl.push_back('{N | J, 4'h9, 1'b0});
    tbl.push_back('{N, 4'hA, 1'b0});
    tbl.push_back('{N | G | FS | U, 4'hD, 1'b0});
    tbl.push_back('{N, 4'hD, 1'b0});
    tbl.push_back('{N | G, 4'hD, 1'b0});
    foreach (tbl[i]) begin
      step(tbl[i].in);
      check($sformatf("vec%0d", i), tbl[i].est, tbl[i].sel);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/unidade_controle.md
Name: unidade_controle

Overview:
- Moore FSM that sequences the memory-game datapath (`fluxo_dados`).
- It drives every datapath control strobe and consumes the datapath status flags.
- Each round has two phases:
  - show the stored sequence on the LEDs, one entry per `fim_timer_leds` period;
  - collect the player's moves, checking each against memory with a per-move timeout.
- The round length grows by one each round until the level's last round is passed, or until a miss or a timeout.

Parameters:
- ESTADO_W, 4, width of the state register and of `db_estado`. Fixed at 4 because there are 16 states.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high; forces state `inicial`.
- iniciar  in  1  start request, level-sensitive, sampled in `inicial` and in the end states.
- nivel  in  1  level select: 0 = half length (`meio`), 1 = full 16-entry game.
- igual, fim_sequencia, ultima_sequencia, jogada_feita, fim_timer, fim_timer_leds  in  1 each  datapath status flags.
- fimE  in  1  endpoint rollover; used for debug only, no transition depends on it.
- zeraR, registraR, limpaM, registraM, contaE, zeraE, contaL, zeraL  out  1 each  datapath strobes.
- zera_timer, conta_timer, zera_timer_leds, conta_timer_leds  out  1 each  timer controls.
- sel_nivel  out  1  registered level selection.
- pronto, acertou, errou, timeout  out  1 each  game result.
- db_estado  out  4  current state code.

Behaviour:
- Reset:
  - State is `inicial` (0x0).
  - All outputs are 0, including `sel_nivel`.
  - Reset asserted mid-game aborts immediately, with no pending strobe.
- Output decoding:
  - All strobes decode only from the state register (Moore), so they are glitch-free.
  - Each strobe is high for exactly the cycles spent in its state.
- States and transitions (hex code, name, outputs asserted, next state):
  - 0 inicial: none. `iniciar` -> 1.
  - 1 preparacao: `zeraE`, `zeraL`, `zeraR`, `limpaM`, `zera_timer`, `zera_timer_leds`. Captures `nivel` into `sel_nivel`. -> 2.
  - 2 le_memoria: none. This wait cycle covers the one-cycle latency of the synchronous ROM. -> 3.
  - 3 mostra_led: `registraM`, `zera_timer_leds`. -> 4.
  - 4 espera_led: `conta_timer_leds`. `fim_timer_leds` -> 5.
  - 5 apaga_led: `limpaM`, `zera_timer_leds`. `fim_sequencia` -> 7, else -> 6.
  - 6 proximo_led: `contaE`. -> 2.
  - 7 inicia_rodada: `zeraE`, `zera_timer`. -> 8.
  - 8 espera_jogada: `conta_timer`. `jogada_feita` -> 9; else `fim_timer` -> F. If both are high in the same cycle, the move wins.
  - 9 registra: `registraR`, `zera_timer`. -> A.
  - A comparacao: no strobes. Decisions in priority order:
    - `!igual` -> E;
    - `igual & fim_sequencia & ultima_sequencia` -> D;
    - `igual & fim_sequencia` -> C;
    - otherwise -> B.
  - B proxima_jogada: `contaE`. -> 8.
  - C proxima_sequencia: `contaL`, `zeraE`. -> 2.
  - D fim_acertou: `pronto`, `acertou`. `iniciar` -> 1, else hold.
  - E fim_errou: `pronto`, `errou`. `iniciar` -> 1, else hold.
  - F fim_timeout: `pronto`, `timeout`. `iniciar` -> 1, else hold.
- `iniciar` is ignored in states 1 through C.
- `sel_nivel`:
  - Loads only in `preparacao`.
  - Holds otherwise, including in the end states, so the result display keeps the level that was played.
- Round 1 is a single entry: `s_limite` is 0 after `zeraL`.
- Wrap-around:
  - There is no wrap-around inside the FSM.
  - The datapath counters are always cleared (`zeraE`) before each showing phase and each play phase.
- Unknown state codes cannot occur (the encoding is full).
- Default arm: next state = `inicial`, all outputs 0.

Decomposition:
- Shared package `jogo_pkg` holds:
  - the 16 state localparams `ST_INICIAL` … `ST_FIM_TIMEOUT` with the codes above;
  - `ESTADO_W`.
- Module structure is a single module with three parts:
  - state register (async reset);
  - combinational next-state logic;
  - combinational output decoder.
- The registered `sel_nivel` flop lives in the same module.
- No sub-module is needed.

Test Plan:
- Reset mid-`espera_led` (`db_estado` = 4) -> `db_estado` = 0 and all outputs 0 in the same cycle as `reset` rises; after release, outputs stay idle until `iniciar`.
- `iniciar` pulse, `nivel` = 1, `fim_timer_leds` after 3 cycles, `fim_sequencia` = 1 -> states go 1, 2, 3, 4, 4, 4, 5, 7, 8; `registraM` is high exactly once, one cycle after `le_memoria`.
- In 8, `jogada_feita`, then `igual` = 1, `fim_sequencia` = 1, `ultima_sequencia` = 0 -> states go 9, A, C, 2; `contaL` and `zeraE` are high for one cycle in C.
- In 8, `jogada_feita`, then `igual` = 0 -> states go 9, A, E; `pronto` = `errou` = 1 and holds; `iniciar` -> state 1 and `zeraL` is asserted.
- In 8, `jogada_feita` and `fim_timer` rise in the same cycle -> next state is 9, not F. A separate run with `fim_timer` alone -> F, with `timeout` = 1.
- `nivel` = 0 at start, then `nivel` = 1 mid-game; final compare with `ultima_sequencia` = 1 -> state D with `acertou` = 1; `sel_nivel` remains 0 throughout.
